gpio_ctrl: RTL
==============

GPIO_CTRL -- requirements
Module: gpio_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, number of pad channels (1..32).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port wen  input  1  register write strobe, one cycle.
REQ-005 SHALL have port ren  input  1  register read strobe, one cycle.
REQ-006 SHALL have port addr  input  4  register index.
REQ-007 SHALL have port wdata  input  N  write data.
REQ-008 SHALL have port rdata  output  N  registered read data.
REQ-009 SHALL have port rvalid  output  1  read data valid pulse.
REQ-010 SHALL have ports di, ie, oe, pu, pd  output  N each  per-channel pad controls to io instances.
REQ-011 SHALL have port dc  input  N  per-channel pad input from io instances, asynchronous to clk.
REQ-012 SHALL have port irq  output  1  level interrupt.

Function
REQ-013 SHALL decode registers: 0 OUT rw, 1 OE rw, 2 IE rw, 3 PU rw, 4 PD rw, 5 IN ro, 6 RISE_EN rw, 7 FALL_EN rw, 8 STATUS w1c; other addresses write-ignored, read 0.
REQ-014 SHALL drive di=OUT, oe=OE, ie=IE, pu=PU, pd=PD & ~PU (pull-up wins when both set), all direct from register flops, no combinational path from bus.
REQ-015 SHALL apply a write in the cycle wen is high; new register value visible on outputs the following cycle.
REQ-016 SHALL return rdata one cycle after ren with rvalid high for exactly that cycle; rdata holds value between reads.
REQ-017 SHALL treat wen and ren in the same cycle to the same address as read-before-write (rdata gets old value).
REQ-018 SHALL synchronize dc through two flops (s1, s2) per channel plus a history flop s3; IN reads s2 masked by IE (bit reads 0 when IE bit 0).
REQ-019 SHALL detect rise = s2 & ~s3 & IE, fall = ~s2 & s3 & IE per channel; latency dc change -> STATUS set is 3 clk edges.
REQ-020 SHALL set STATUS bit on (rise & RISE_EN) | (fall & FALL_EN); bit stays set until cleared.
REQ-021 SHALL clear STATUS bits written as 1 to addr 8; bits written 0 unchanged.
REQ-022 SHALL give set priority over clear when an edge event and a w1c hit the same bit in the same cycle.
REQ-023 SHALL not set STATUS on edge events for channels whose enable is 0, and SHALL not retro-set when enable is later raised.
REQ-024 SHALL drive irq = |STATUS, registered-free OR of STATUS flops.
REQ-025 SHALL suppress edge detection while IE bit is 0; toggling IE 0->1 with pad high SHALL produce a rise event (gated history).

Reset
REQ-026 SHALL on rst force OUT=0, OE=0, IE=all ones, PU=0, PD=0, RISE_EN=0, FALL_EN=0, STATUS=0, s1/s2/s3=0, rdata=0, rvalid=0, irq=0.
REQ-027 SHALL abandon any in-flight read on rst; no rvalid after release until a new ren.
REQ-028 SHALL tolerate rst assertion mid-cycle without glitching oe high; rst release synchronous use only, no bus access needed first cycle.

Verification
REQ-029 SHALL verify: rst release, read addr 2 -> rdata=0xFF, rvalid one cycle after ren; all pad outputs 0 except ie=0xFF.
REQ-030 SHALL verify: write OE=0x0F, OUT=0x05 -> oe=0x0F, di=0x05 next cycle; write PU=0x03, PD=0x06 -> pu=0x03, pd=0x04.
REQ-031 SHALL verify: RISE_EN=0x01, dc[0] 0->1 -> STATUS=0x01 and irq=1 after 3 edges; write 0x01 to addr 8 -> irq=0.
REQ-032 SHALL verify: FALL_EN=0x80, dc[7] falls in same cycle as w1c of bit 7 -> STATUS bit 7 remains 1.
REQ-033 SHALL verify: IE=0xFE, RISE_EN=0xFF, dc[0] toggles -> STATUS stays 0, IN bit0 reads 0.
REQ-034 SHALL verify: rst asserted between ren and rvalid with STATUS=0xFF -> rvalid stays 0, irq=0, ie=0xFF immediately.

Source files
------------

// File: rtl/gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gpio_ctrl
// Brief    : Register-mapped GPIO pad controller with edge-capture interrupt.
// Revision : 1.0 - initial release
// ============================================================================

module gpio_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wen,
    input  logic         ren,
    input  logic [3:0]   addr,
    input  logic [N-1:0] wdata,
    output logic [N-1:0] rdata,
    output logic         rvalid,
    output logic [N-1:0] di,
    output logic [N-1:0] ie,
    output logic [N-1:0] oe,
    output logic [N-1:0] pu,
    output logic [N-1:0] pd,
    input  logic [N-1:0] dc,
    output logic         irq
);

    localparam logic [3:0] c_ADDR_OUT     = 4'd0;
    localparam logic [3:0] c_ADDR_OE      = 4'd1;
    localparam logic [3:0] c_ADDR_IE      = 4'd2;
    localparam logic [3:0] c_ADDR_PU      = 4'd3;
    localparam logic [3:0] c_ADDR_PD      = 4'd4;
    localparam logic [3:0] c_ADDR_IN      = 4'd5;
    localparam logic [3:0] c_ADDR_RISE_EN = 4'd6;
    localparam logic [3:0] c_ADDR_FALL_EN = 4'd7;
    localparam logic [3:0] c_ADDR_STATUS  = 4'd8;

    logic [N-1:0] r_out;
    logic [N-1:0] r_oe;
    logic [N-1:0] r_ie;
    logic [N-1:0] r_pu;
    logic [N-1:0] r_pd;
    logic [N-1:0] r_rise_en;
    logic [N-1:0] r_fall_en;
    logic [N-1:0] r_status;
    logic [N-1:0] r_s1;
    logic [N-1:0] r_s2;
    logic [N-1:0] r_s3;
    logic [N-1:0] r_rdata;
    logic         r_rvalid;

    logic [N-1:0] w_in;
    logic [N-1:0] w_rise;
    logic [N-1:0] w_fall;
    logic [N-1:0] w_set;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_rd_mux;

    // Control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out     <= '0;
            r_oe      <= '0;
            r_ie      <= '1;
            r_pu      <= '0;
            r_pd      <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else if (wen) begin
            case (addr)
                c_ADDR_OUT:     r_out     <= wdata;
                c_ADDR_OE:      r_oe      <= wdata;
                c_ADDR_IE:      r_ie      <= wdata;
                c_ADDR_PU:      r_pu      <= wdata;
                c_ADDR_PD:      r_pd      <= wdata;
                c_ADDR_RISE_EN: r_rise_en <= wdata;
                c_ADDR_FALL_EN: r_fall_en <= wdata;
                default:        ;
            endcase
        end
    end

    // History flop is gated by IE so re-enabling a high pad reports a rise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= dc;
            r_s2 <= r_s1;
            r_s3 <= r_s2 & r_ie;
        end
    end

    assign w_in   = r_s2 & r_ie;
    assign w_rise = r_s2 & ~r_s3 & r_ie;
    assign w_fall = ~r_s2 & r_s3 & r_ie;
    assign w_set  = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_clr  = (wen && (addr == c_ADDR_STATUS)) ? wdata : '0;

    // Set is applied after clear so a coincident edge event wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status <= '0;
        end else begin
            r_status <= (r_status & ~w_clr) | w_set;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (addr)
            c_ADDR_OUT:     w_rd_mux = r_out;
            c_ADDR_OE:      w_rd_mux = r_oe;
            c_ADDR_IE:      w_rd_mux = r_ie;
            c_ADDR_PU:      w_rd_mux = r_pu;
            c_ADDR_PD:      w_rd_mux = r_pd;
            c_ADDR_IN:      w_rd_mux = w_in;
            c_ADDR_RISE_EN: w_rd_mux = r_rise_en;
            c_ADDR_FALL_EN: w_rd_mux = r_fall_en;
            c_ADDR_STATUS:  w_rd_mux = r_status;
            default:        w_rd_mux = '0;
        endcase
    end

    // Read samples pre-write state, giving read-before-write on collisions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= ren;
            if (ren) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign di     = r_out;
    assign oe     = r_oe;
    assign ie     = r_ie;
    assign pu     = r_pu;
    assign pd     = r_pd & ~r_pu;
    assign irq    = |r_status;

endmodule

`default_nettype wire
